// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if
//   Bundles the three buses around the data-memory arbiter:
//   pipeline MEM-stage port (i_p_* / o_p_*), debug dump stream
//   (i_halted, i_d_* / o_d_*) and the single-port memory (o_mem_* / i_mem_rdata).
//   Signal names carry the arbiter's point of view.
//   modport slave  : the arbiter side
//   modport master : the surrounding system (pipeline, debug unit, memory)
interface dmem_arbiter_if #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7
);
    logic               i_p_req;
    logic               i_p_read;
    logic               i_p_write;
    logic [NB_ADDR-1:0] i_p_addr;
    logic [NB_DATA-1:0] i_p_wdata;
    logic [NB_DATA-1:0] o_p_rdata;
    logic               o_p_stall;

    logic               i_halted;
    logic               i_d_start;
    logic               i_d_ready;
    logic [NB_DATA-1:0] o_d_data;
    logic               o_d_valid;
    logic               o_d_busy;
    logic               o_d_done;

    logic               o_mem_enable;
    logic               o_mem_read;
    logic               o_mem_write;
    logic [NB_ADDR-1:0] o_mem_addr;
    logic [NB_DATA-1:0] o_mem_wdata;
    logic [NB_DATA-1:0] i_mem_rdata;

    modport slave (
        input  i_p_req, i_p_read, i_p_write, i_p_addr, i_p_wdata,
        output o_p_rdata, o_p_stall,
        input  i_halted, i_d_start, i_d_ready,
        output o_d_data, o_d_valid, o_d_busy, o_d_done,
        output o_mem_enable, o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata,
        input  i_mem_rdata
    );

    modport master (
        output i_p_req, i_p_read, i_p_write, i_p_addr, i_p_wdata,
        input  o_p_rdata, o_p_stall,
        output i_halted, i_d_start, i_d_ready,
        input  o_d_data, o_d_valid, o_d_busy, o_d_done,
        input  o_mem_enable, o_mem_read, o_mem_write, o_mem_addr, o_mem_wdata,
        output i_mem_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter
//   Shares the single-port data memory between the pipeline MEM stage and
//   the debug unit. In IDLE the pipeline drives the memory combinationally.
//   While the core is halted a start pulse launches a sweep of all N_WORDS
//   words, each handed out on a valid/ready stream.
// Ports
//   i_clock : system clock, rising edge
//   i_reset : asynchronous, active-high reset
//   bus     : dmem_arbiter_if.slave (pipeline, debug stream, memory)
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | pipeline owns memory, pass-through, no stall
// READ  | memory read of word cnt; data captured at the next edge
// WAIT  | word held on o_d_data/o_d_valid until i_d_ready
// DONE  | one-cycle o_d_done pulse after the last word was accepted
module dmem_arbiter #(
    parameter int NB_DATA = 32,
    parameter int NB_ADDR = 7,
    parameter int N_WORDS = 128
) (
    input  logic            i_clock,
    input  logic            i_reset,
    dmem_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [NB_ADDR-1:0] LAST_ADDR = NB_ADDR'(N_WORDS - 1);

    state_t             state, state_next;
    logic [NB_ADDR-1:0] cnt, cnt_next;
    logic [NB_DATA-1:0] d_data, d_data_next;
    logic               d_valid, d_valid_next;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= S_IDLE;
            cnt     <= '0;
            d_data  <= '0;
            d_valid <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            d_data  <= d_data_next;
            d_valid <= d_valid_next;
        end
    end

    always_comb begin
        state_next       = state;
        cnt_next         = cnt;
        d_data_next      = d_data;
        d_valid_next     = d_valid;
        bus.o_mem_enable = 1'b0;
        bus.o_mem_read   = 1'b0;
        bus.o_mem_write  = 1'b0;
        bus.o_mem_addr   = '0;
        bus.o_mem_wdata  = '0;
        // Outside IDLE any pipeline request is blocked.
        bus.o_p_stall    = bus.i_p_req;

        case (state)
            S_IDLE: begin
                bus.o_mem_enable = bus.i_p_req;
                bus.o_mem_read   = bus.i_p_read;
                bus.o_mem_write  = bus.i_p_write;
                bus.o_mem_addr   = bus.i_p_addr;
                bus.o_mem_wdata  = bus.i_p_wdata;
                bus.o_p_stall    = 1'b0;
                // A pipeline access sampled together with the start still
                // completes this cycle; the sweep begins next cycle.
                if (bus.i_d_start && bus.i_halted) begin
                    state_next = S_READ;
                    cnt_next   = '0;
                end
            end
            S_READ: begin
                bus.o_mem_enable = 1'b1;
                bus.o_mem_read   = 1'b1;
                bus.o_mem_addr   = cnt;
                if (!bus.i_halted) begin
                    state_next   = S_IDLE;
                    cnt_next     = '0;
                    d_valid_next = 1'b0;
                end else begin
                    // Memory has refreshed rdata on the falling edge.
                    d_data_next  = bus.i_mem_rdata;
                    d_valid_next = 1'b1;
                    state_next   = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!bus.i_halted) begin
                    state_next   = S_IDLE;
                    cnt_next     = '0;
                    d_valid_next = 1'b0;
                end else if (bus.i_d_ready) begin
                    d_valid_next = 1'b0;
                    // Terminal compare before increment: cnt never wraps.
                    if (cnt == LAST_ADDR) begin
                        state_next = S_DONE;
                    end else begin
                        cnt_next   = cnt + NB_ADDR'(1);
                        state_next = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
                cnt_next   = '0;
            end
            default: begin
                state_next   = S_IDLE;
                cnt_next     = '0;
                d_valid_next = 1'b0;
            end
        endcase
    end

    assign bus.o_p_rdata = bus.i_mem_rdata;
    assign bus.o_d_data  = d_data;
    assign bus.o_d_valid = d_valid;
    assign bus.o_d_busy  = (state != S_IDLE);
    assign bus.o_d_done  = (state == S_DONE);

endmodule
